ss_regbank: RTL
===============

# ss_regbank

Parametrised successor to the single shift/storage register: a bank of DEPTH registers of WIDTH bits with addressable parallel load, multi-cycle shift/rotate by a programmable amount, and an optional whole-bank serial chain mode. It sits behind the tile's pin-mapping top level. A valid/ready command port feeds it. It exposes a combinational read port, a serial output bit and a one-cycle completion pulse.

## Interface
- WIDTH, 8: bits per entry (≥2)
- DEPTH, 4: number of entries (≥1)
- AMT_W, $clog2(DEPTH*WIDTH+1): width of shift amount
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- ena  in  1  global enable; low freezes all state
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when valid&ready on a clk edge
- cmd_op  in  3  opcode (see Operation)
- cmd_addr  in  $clog2(DEPTH) (min 1)  target entry
- cmd_amt  in  AMT_W  shift count
- cmd_data  in  WIDTH  load data
- ser_in  in  1  fill bit for SHL/SHR/CHAIN, sampled every shift step
- rd_addr  in  $clog2(DEPTH) (min 1)  read select
- rd_data  out  WIDTH  combinational bank[rd_addr]; 0 if rd_addr ≥ DEPTH
- ser_out  out  1  registered: last bit shifted/rotated out
- done  out  1  one-cycle pulse on op completion

## Operation
- Opcodes:
  - 0 NOP.
  - 1 LOAD: bank[addr]=data.
  - 2 CLEAR: all entries 0.
  - 3 SHL: entry shifts left, ser_in into LSB.
  - 4 SHR: entry shifts right, ser_in into MSB.
  - 5 ROL.
  - 6 ROR.
  - 7 CHAIN: bank treated as one DEPTH*WIDTH vector, entry 0 least significant. Shift left one bit per step, ser_in into bit 0, top bit out.
- FSM states IDLE, SHIFT. cmd_ready = ena && state==IDLE.
- Single-cycle ops (NOP, LOAD, CLEAR, any shift op with cmd_amt==0): executed on the accept edge; stay IDLE.
- Shift ops with amt>0: the accept edge performs step 1 and loads remaining count = amt-1. If the remaining count is 0 the FSM stays IDLE. Otherwise it moves to SHIFT. Each further enabled edge performs one step and decrements the count. The edge whose step leaves the count at 0 returns the FSM to IDLE.
- Operation target (op, addr) is latched at accept; cmd_* may change afterwards.
- amt > WIDTH is legal for per-entry ops: the full count of steps is performed. Shifts saturate to fill bits; rotates wrap.
- ser_out updates on every step with the bit that left (SHL/ROL/CHAIN: MSB of operand; SHR/ROR: LSB). Otherwise it holds.
- addr ≥ DEPTH (non-power-of-two DEPTH): writes/shifts do not modify the bank; step count and done timing are unchanged.
- ena low: no state change, count paused, cmd_ready low, done low.
- Reset (any time, including mid-SHIFT): bank=0, state IDLE, count=0, ser_out=0, done=0. The aborted op produces no done.

## Timing
- done is registered. It is high for exactly the one cycle following the edge that completes the op.
- LOAD/CLEAR/NOP: bank visible on rd_data the cycle after accept; done the same cycle.
- Shift by n≥1: busy n edges including accept. cmd_ready is low for n-1 cycles after accept. done follows the n-th edge.
- Back-to-back: a new command may be accepted on the edge after done rises (cmd_ready is high in that cycle).

## Configuration
- SS_REGBANK_CHAIN_EN defined: opcode 7 is CHAIN as above.
- Undefined: CHAIN logic is not built. Opcode 7 executes as NOP: single cycle, done pulse, no bank or ser_out change.

## Structure
- Package ss_regbank_pkg: opcode enum (OP_NOP…OP_CHAIN), FSM state enum, and a function is_shift_op(op).
- One sub-module ss_shift_step: combinational one-step shifter (inputs: operand WIDTH, op, fill bit; outputs: next value, out bit). It is instantiated once for per-entry ops. The CHAIN path is a separate wide shift in the top.

## Test plan
- Reset then LOAD addr 2 data 0xA5 → rd_addr=2 reads 0xA5 next cycle; done pulses once; other entries read 0.
- entry1=0x81, ROL amt 3 → 3 busy edges, cmd_ready low 2 cycles, result 0x0C, ser_out=0, single done.
- entry0=0xF0, SHR amt 10 with ser_in=0 → entry0=0x00 after 10 steps; ser_out=0.
- With CHAIN_EN: entry0=0x80, others 0, CHAIN amt 1, ser_in=1 → entry0=0x01, entry1=0x01. Without the macro: bank unchanged, done after 1 cycle.
- Mid-SHIFT: drop ena for 4 cycles → state and count frozen; completion is delayed by exactly 4 cycles.
- Assert rst_n low mid-SHIFT → all entries 0, cmd_ready high after release, no done pulse.

Source files
------------

// File: rtl/ss_regbank_pkg.sv
// rtl/ss_regbank_pkg.sv - opcodes, FSM states and helpers for ss_regbank
// CHAIN is only treated as a shift op when SS_REGBANK_CHAIN_EN is defined.
package ss_regbank_pkg;

    typedef enum logic [2:0] {
        OP_NOP   = 3'd0,
        OP_LOAD  = 3'd1,
        OP_CLEAR = 3'd2,
        OP_SHL   = 3'd3,
        OP_SHR   = 3'd4,
        OP_ROL   = 3'd5,
        OP_ROR   = 3'd6,
        OP_CHAIN = 3'd7
    } op_e;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_e;

    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic logic is_shift_op(input op_e op);
`ifdef SS_REGBANK_CHAIN_EN
        return op inside {OP_SHL, OP_SHR, OP_ROL, OP_ROR, OP_CHAIN};
`else
        return op inside {OP_SHL, OP_SHR, OP_ROL, OP_ROR};
`endif
    endfunction

endpackage

// File: rtl/ss_regbank_if.sv
// rtl/ss_regbank_if.sv - valid/ready command port of ss_regbank
interface ss_regbank_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) ();
    localparam int ADDR_W = ss_regbank_pkg::addr_w(DEPTH);
    localparam int AMT_W  = $clog2(DEPTH * WIDTH + 1);

    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [AMT_W-1:0]  cmd_amt;
    logic [WIDTH-1:0]  cmd_data;

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_amt, cmd_data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_amt, cmd_data,
        output cmd_ready
    );
endinterface

// File: rtl/ss_shift_step.sv
// rtl/ss_shift_step.sv - one combinational shift/rotate step on a single entry
module ss_shift_step
    import ss_regbank_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] operand_i,
    input  op_e              op_i,
    input  logic             fill_i,
    output logic [WIDTH-1:0] next_o,
    output logic             out_bit_o
);

    always_comb begin
        next_o    = operand_i;
        out_bit_o = 1'b0;
        case (op_i)
            OP_SHL: begin
                next_o    = {operand_i[WIDTH-2:0], fill_i};
                out_bit_o = operand_i[WIDTH-1];
            end
            OP_SHR: begin
                next_o    = {fill_i, operand_i[WIDTH-1:1]};
                out_bit_o = operand_i[0];
            end
            OP_ROL: begin
                next_o    = {operand_i[WIDTH-2:0], operand_i[WIDTH-1]};
                out_bit_o = operand_i[WIDTH-1];
            end
            OP_ROR: begin
                next_o    = {operand_i[0], operand_i[WIDTH-1:1]};
                out_bit_o = operand_i[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ss_regbank.sv
// rtl/ss_regbank.sv - register bank with load/clear and multi-cycle shift/rotate
// Whole-bank CHAIN shifting is built only when SS_REGBANK_CHAIN_EN is defined.
module ss_regbank
    import ss_regbank_pkg::*;
#(
    parameter int  WIDTH  = 8,
    parameter int  DEPTH  = 4,
    parameter int  AMT_W  = $clog2(DEPTH * WIDTH + 1),
    localparam int ADDR_W = addr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    ss_regbank_if.slave       cmd,
    input  logic              ser_in,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data,
    output logic              ser_out,
    output logic              done
);

    state_e            state_q, state_d;
    logic [AMT_W-1:0]  cnt_q, cnt_d;
    op_e               op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WIDTH-1:0]  bank_q [DEPTH];
    logic [WIDTH-1:0]  bank_d [DEPTH];
    logic              ser_out_q, ser_out_d;
    logic              done_q, done_d;

    op_e               step_op;
    logic [ADDR_W-1:0] step_addr;
    logic              step_addr_ok;
    logic [WIDTH-1:0]  step_operand;
    logic [WIDTH-1:0]  step_next;
    logic              step_out;
    logic              do_step;

    // While idle the step acts on the command being accepted; afterwards on the latched target.
    assign step_op      = (state_q == S_IDLE) ? op_e'(cmd.cmd_op) : op_q;
    assign step_addr    = (state_q == S_IDLE) ? cmd.cmd_addr : addr_q;
    assign step_operand = step_addr_ok ? bank_q[step_addr] : '0;

    if (DEPTH == (1 << ADDR_W)) begin : g_pow2
        assign step_addr_ok = 1'b1;
        assign rd_data      = bank_q[rd_addr];
    end else begin : g_npow2
        assign step_addr_ok = (step_addr < ADDR_W'(DEPTH));
        assign rd_data      = (rd_addr < ADDR_W'(DEPTH)) ? bank_q[rd_addr] : '0;
    end

    ss_shift_step #(.WIDTH(WIDTH)) u_step (
        .operand_i (step_operand),
        .op_i      (step_op),
        .fill_i    (ser_in),
        .next_o    (step_next),
        .out_bit_o (step_out)
    );

`ifdef SS_REGBANK_CHAIN_EN
    logic [DEPTH*WIDTH-1:0] chain_vec;
    logic [DEPTH*WIDTH-1:0] chain_next;

    always_comb begin
        chain_vec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            chain_vec[i*WIDTH +: WIDTH] = bank_q[i];
        end
    end

    assign chain_next = {chain_vec[DEPTH*WIDTH-2:0], ser_in};
`endif

    assign cmd.cmd_ready = ena && (state_q == S_IDLE);
    assign ser_out       = ser_out_q;
    assign done          = done_q && ena;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        addr_d    = addr_q;
        bank_d    = bank_q;
        ser_out_d = ser_out_q;
        done_d    = 1'b0;
        do_step   = 1'b0;

        if (ena) begin
            case (state_q)
                S_IDLE: begin
                    if (cmd.cmd_valid) begin
                        op_d   = op_e'(cmd.cmd_op);
                        addr_d = cmd.cmd_addr;
                        if (is_shift_op(op_e'(cmd.cmd_op)) && (cmd.cmd_amt != '0)) begin
                            do_step = 1'b1;
                            cnt_d   = cmd.cmd_amt - 1'b1;
                            if (cnt_d == '0) begin
                                done_d = 1'b1;
                            end else begin
                                state_d = S_SHIFT;
                            end
                        end else begin
                            done_d = 1'b1;
                            if (op_e'(cmd.cmd_op) == OP_LOAD && step_addr_ok) begin
                                bank_d[cmd.cmd_addr] = cmd.cmd_data;
                            end
                            if (op_e'(cmd.cmd_op) == OP_CLEAR) begin
                                for (int i = 0; i < DEPTH; i++) begin
                                    bank_d[i] = '0;
                                end
                            end
                        end
                    end
                end
                S_SHIFT: begin
                    do_step = 1'b1;
                    cnt_d   = cnt_q - 1'b1;
                    if (cnt_d == '0) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase

            if (do_step) begin
`ifdef SS_REGBANK_CHAIN_EN
                if (step_op == OP_CHAIN) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        bank_d[i] = chain_next[i*WIDTH +: WIDTH];
                    end
                    ser_out_d = chain_vec[DEPTH*WIDTH-1];
                end else
`endif
                if (step_addr_ok) begin
                    bank_d[step_addr] = step_next;
                    ser_out_d         = step_out;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            op_q      <= OP_NOP;
            addr_q    <= '0;
            ser_out_q <= 1'b0;
            done_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                bank_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            ser_out_q <= ser_out_d;
            done_q    <= done_d;
            bank_q    <= bank_d;
        end
    end

endmodule
